// File: rtl/mult4u_pkg.sv
// Shared types and sizes for the redundant 4x4 multiplier arbiter.
package mult4u_pkg;
   localparam int unsigned OP_W          = 4;
   localparam int unsigned PROD_W        = 8;
   localparam int unsigned MAX_RETRY_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2,
      ST_RESP  = 2'd3
   } state_t;
endpackage

// File: rtl/mult4u_arb_ctrl_if.sv
// Request/response bundle between two requesters, the arbiter and the consumer.
interface mult4u_arb_ctrl_if
   import mult4u_pkg::*;
#(
   parameter int unsigned ERRCNT_W = 8
);
   logic                req0_valid, req1_valid;
   logic                req0_ready, req1_ready;
   logic [OP_W-1:0]     req0_a, req0_b, req1_a, req1_b;
   logic                fault_inj;
   logic                rsp_valid, rsp_ready;
   logic                rsp_id;
   logic [PROD_W-1:0]   rsp_prod;
   logic                rsp_err;
   logic [ERRCNT_W-1:0] err_cnt;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      input  fault_inj, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, err_cnt
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      output fault_inj, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, err_cnt
   );
endinterface

// File: rtl/mult4u_arb_ctrl_core.sv
// Purely combinational 4x4 -> 8 unsigned multiplier shared by both passes.
module mult4u_core
   import mult4u_pkg::*;
(
   input  logic [OP_W-1:0]   i_a,
   input  logic [OP_W-1:0]   i_b,
   output logic [PROD_W-1:0] o_p
);
   assign o_p = PROD_W'(i_a) * PROD_W'(i_b);
endmodule

// File: rtl/mult4u_arb_ctrl.sv
// Round-robin arbiter feeding one multiplier twice (A*B then B*A) and comparing.
// Optional re-execution on mismatch is enabled by defining MULT4U_ARB_RETRY_EN.
module mult4u_arb_ctrl
   import mult4u_pkg::*;
#(
   parameter int unsigned MAX_RETRY = MAX_RETRY_DEF,
   parameter int unsigned ERRCNT_W  = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   mult4u_arb_ctrl_if.slave  bus
);
   state_t              r_state, w_next;
   logic                r_prio;
   logic                r_id;
   logic [OP_W-1:0]     r_a, r_b;
   logic [PROD_W-1:0]   r_p1;
   logic                r_err;
   logic [ERRCNT_W-1:0] r_err_cnt;

   logic                w_grant_id, w_grant_vld;
   logic                w_rdy0, w_rdy1;
   logic                w_accept, w_load_p1, w_to_resp, w_err_set, w_rsp_done;
   logic                w_match, w_rsp_valid;
   logic [OP_W-1:0]     w_mul_a, w_mul_b;
   logic [PROD_W-1:0]   w_mul_p, w_p2;
`ifdef MULT4U_ARB_RETRY_EN
   localparam logic [1:0] MAXR = 2'(MAX_RETRY);
   logic [1:0]          r_retry;
   logic                w_retry;
`endif

   // Contention goes to r_prio; a lone requester always wins.
   assign w_grant_vld = bus.req0_valid | bus.req1_valid;
   assign w_grant_id  = (bus.req0_valid & bus.req1_valid) ? r_prio : bus.req1_valid;

   // PASS2 feeds the operands swapped through the same multiplier.
   assign w_mul_a = (r_state == ST_PASS2) ? r_b : r_a;
   assign w_mul_b = (r_state == ST_PASS2) ? r_a : r_b;

   mult4u_core u_core (
      .i_a (w_mul_a),
      .i_b (w_mul_b),
      .o_p (w_mul_p)
   );

   assign w_p2    = w_mul_p ^ {{(PROD_W-1){1'b0}}, bus.fault_inj};
   assign w_match = (w_p2 == r_p1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_rdy0     = 1'b0;
      w_rdy1     = 1'b0;
      w_accept   = 1'b0;
      w_load_p1  = 1'b0;
      w_to_resp  = 1'b0;
      w_err_set  = 1'b0;
      w_rsp_done = 1'b0;
`ifdef MULT4U_ARB_RETRY_EN
      w_retry    = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (rst_n && w_grant_vld) begin
               w_rdy0   = ~w_grant_id;
               w_rdy1   = w_grant_id;
               w_accept = 1'b1;
               w_next   = ST_PASS1;
            end
         end
         ST_PASS1: begin
            w_load_p1 = 1'b1;
            w_next    = ST_PASS2;
         end
         ST_PASS2: begin
            if (w_match) begin
               w_to_resp = 1'b1;
               w_next    = ST_RESP;
            end else begin
`ifdef MULT4U_ARB_RETRY_EN
               if (r_retry < MAXR) begin
                  w_retry = 1'b1;
                  w_next  = ST_PASS1;
               end else begin
                  w_to_resp = 1'b1;
                  w_err_set = 1'b1;
                  w_next    = ST_RESP;
               end
`else
               w_to_resp = 1'b1;
               w_err_set = 1'b1;
               w_next    = ST_RESP;
`endif
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               w_rsp_done = 1'b1;
               w_next     = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio    <= 1'b0;
         r_id      <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_p1      <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
`ifdef MULT4U_ARB_RETRY_EN
         r_retry   <= '0;
`endif
      end else begin
         if (w_accept) begin
            r_id   <= w_grant_id;
            r_a    <= w_grant_id ? bus.req1_a : bus.req0_a;
            r_b    <= w_grant_id ? bus.req1_b : bus.req0_b;
            r_prio <= ~w_grant_id;
`ifdef MULT4U_ARB_RETRY_EN
            r_retry <= '0;
`endif
         end
`ifdef MULT4U_ARB_RETRY_EN
         if (w_retry) r_retry <= r_retry + 2'd1;
`endif
         if (w_load_p1) r_p1  <= w_mul_p;
         if (w_to_resp) r_err <= w_err_set;
         if (w_rsp_done && r_err && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
      end
   end

   assign w_rsp_valid    = (r_state == ST_RESP);
   assign bus.req0_ready = w_rdy0;
   assign bus.req1_ready = w_rdy1;
   assign bus.rsp_valid  = w_rsp_valid;
   assign bus.rsp_id     = w_rsp_valid & r_id;
   assign bus.rsp_prod   = w_rsp_valid ? r_p1 : '0;
   assign bus.rsp_err    = w_rsp_valid & r_err;
   assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_mult4u_arb_ctrl.sv
// Bench for mult4u_arb_ctrl: timestamp-based reference model, vector table and corner sequences.
module tb_mult4u_arb_ctrl;
   import mult4u_pkg::*;

   localparam int unsigned MAXR   = 2;
   localparam int unsigned EW     = 4;
   localparam int          ERRMAX = 15;
`ifdef MULT4U_ARB_RETRY_EN
   localparam int FLAT = 2 + 2 * MAXR;
`else
   localparam int FLAT = 2;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mult4u_arb_ctrl_if #(.ERRCNT_W(EW)) bus ();

   mult4u_arb_ctrl #(.MAX_RETRY(MAXR), .ERRCNT_W(EW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model: one outstanding op, visible from cycle m_vis until handshaken.
   bit m_pend;
   int m_id, m_prod, m_err, m_vis, m_prio, m_errcnt;

   typedef struct {
      bit v0, v1;
      int a0, b0, a1, b1;
      int exp_id, exp_prod;
   } vec_t;
   vec_t tbl[10];

   function automatic vec_t mkv(bit v0, bit v1, int a0, int b0, int a1, int b1, int id, int p);
      vec_t v;
      v.v0 = v0; v.v1 = v1; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
      v.exp_id = id; v.exp_prod = p;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic drive_idle();
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
      bus.fault_inj = 1'b0; bus.rsp_ready = 1'b1;
   endtask

   task automatic model_step();
      int g;
      bit ev;
      int a, b;
      if (!rst_n) begin
         m_pend = 0; m_prio = 0; m_errcnt = 0;
         chk("rst_ready0", int'(bus.req0_ready), 0);
         chk("rst_ready1", int'(bus.req1_ready), 0);
         chk("rst_valid",  int'(bus.rsp_valid), 0);
         chk("rst_prod",   int'(bus.rsp_prod), 0);
         chk("rst_errcnt", int'(bus.err_cnt), 0);
         return;
      end
      ev = m_pend && (cyc >= m_vis);
      g = -1;
      if (!m_pend) begin
         if (bus.req0_valid && bus.req1_valid) g = m_prio;
         else if (bus.req0_valid) g = 0;
         else if (bus.req1_valid) g = 1;
      end
      chk("ready0",    int'(bus.req0_ready), int'(g == 0));
      chk("ready1",    int'(bus.req1_ready), int'(g == 1));
      chk("rsp_valid", int'(bus.rsp_valid),  int'(ev));
      chk("rsp_id",    int'(bus.rsp_id),     ev ? m_id   : 0);
      chk("rsp_prod",  int'(bus.rsp_prod),   ev ? m_prod : 0);
      chk("rsp_err",   int'(bus.rsp_err),    ev ? m_err  : 0);
      chk("err_cnt",   int'(bus.err_cnt),    m_errcnt);
      if (ev && bus.rsp_ready) begin
         m_pend = 0;
         if (m_err != 0 && m_errcnt < ERRMAX) m_errcnt++;
      end else if (g >= 0) begin
         a = (g == 1) ? int'(bus.req1_a) : int'(bus.req0_a);
         b = (g == 1) ? int'(bus.req1_b) : int'(bus.req0_b);
         m_pend = 1;
         m_id   = g;
         m_prod = a * b;
         m_err  = int'(bus.fault_inj);
         m_vis  = cyc + 1 + (bus.fault_inj ? FLAT : 2);
         m_prio = 1 - g;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      #1 model_step();
      @(negedge clk);
      #1 model_step();
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      bit done;
      done = 0;
      @(negedge clk);
      bus.req0_valid = v.v0; bus.req1_valid = v.v1;
      bus.req0_a = 4'(v.a0); bus.req0_b = 4'(v.b0);
      bus.req1_a = 4'(v.a1); bus.req1_b = 4'(v.b1);
      bus.fault_inj = 1'b0; bus.rsp_ready = 1'b1;
      #1;
      chk("vec_grant", int'({bus.req1_ready, bus.req0_ready}), (v.exp_id == 1) ? 2 : 1);
      model_step();
      for (int i = 0; i < 12 && !done; i++) begin
         @(negedge clk);
         bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
         #1;
         if (bus.rsp_valid) begin
            chk("vec_lat",  i + 1, 3);
            chk("vec_id",   int'(bus.rsp_id), v.exp_id);
            chk("vec_prod", int'(bus.rsp_prod), v.exp_prod);
            done = 1;
         end
         model_step();
      end
      if (!done) chk("vec_timeout", 0, 1);
   endtask

   task automatic rand_cycle();
      @(negedge clk);
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req1_valid = 1'($urandom_range(0, 1));
      bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom);
      bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (!m_pend) bus.fault_inj = ($urandom_range(0, 3) == 0);
      #1 model_step();
   endtask

   initial begin
      int n, e0, exp_n, exp_e;
      bit got;
      drive_idle();

      tbl[0] = mkv(1, 0, 15, 15, 0,  0,  0, 225);
      tbl[1] = mkv(0, 1, 0,  0,  0,  9,  1, 0);
      tbl[2] = mkv(1, 1, 3,  5,  7,  9,  0, 15);
      tbl[3] = mkv(1, 1, 3,  5,  7,  9,  1, 63);
      tbl[4] = mkv(1, 1, 3,  5,  7,  9,  0, 15);
      tbl[5] = mkv(1, 1, 3,  5,  7,  9,  1, 63);
      tbl[6] = mkv(0, 1, 0,  0,  15, 1,  1, 15);
      tbl[7] = mkv(1, 1, 2,  8,  4,  4,  0, 16);
      tbl[8] = mkv(1, 0, 1,  15, 0,  0,  0, 15);
      tbl[9] = mkv(1, 1, 0,  0,  15, 14, 1, 210);

      do_reset();
      for (int i = 0; i < 10; i++) run_vec(tbl[i]);

      // Consumer stalls for 5 cycles while both requesters stay valid.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
         bus.req0_a = 4'd9; bus.req0_b = 4'd9; bus.req1_a = 4'd2; bus.req1_b = 4'd3;
         bus.fault_inj = 1'b0;
         bus.rsp_ready = (i >= 8);
         #1;
         if (i >= 3 && i <= 8) chk("bp_hold", int'(bus.rsp_prod), 81);
         if (i == 9) chk("bp_next_grant1", int'(bus.req1_ready), 1);
         model_step();
      end

      // Continuous fault injection.
      do_reset();
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd3;
      bus.fault_inj = 1'b1; bus.rsp_ready = 1'b1;
      #1 model_step();
      got = 0; n = 0; e0 = int'(bus.err_cnt);
      for (int i = 1; i < 20 && !got; i++) begin
         @(negedge clk);
         bus.req0_valid = 1'b0;
         #1;
         if (bus.rsp_valid) begin
            got = 1; n = i;
            chk("flt_lat",  n, FLAT + 1);
            chk("flt_err",  int'(bus.rsp_err), 1);
            chk("flt_prod", int'(bus.rsp_prod), 15);
         end
         model_step();
      end
      if (!got) chk("flt_timeout", 0, 1);
      @(negedge clk);
      bus.fault_inj = 1'b0;
      #1;
      chk("flt_errcnt", int'(bus.err_cnt), e0 + 1);
      model_step();

      // Fault during the first PASS2 only.
      do_reset();
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = 4'd6; bus.req0_b = 4'd7;
      bus.fault_inj = 1'b0; bus.rsp_ready = 1'b1;
`ifdef MULT4U_ARB_RETRY_EN
      exp_n = 5; exp_e = 0;
`else
      exp_n = 3; exp_e = 1;
`endif
      got = 0;
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         bus.req0_valid = 1'b0;
         bus.fault_inj = (i == 2);
         #1;
         if (bus.rsp_valid && !got) begin
            got = 1;
            chk("pulse_lat",  i, exp_n);
            chk("pulse_err",  int'(bus.rsp_err), exp_e);
            chk("pulse_prod", int'(bus.rsp_prod), 42);
         end
      end
      if (!got) chk("pulse_timeout", 0, 1);

      // Reset asserted mid-operation during PASS2.
      do_reset();
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = 4'd11; bus.req0_b = 4'd13;
      #1 model_step();
      @(negedge clk);
      bus.req0_valid = 1'b0;
      #1 model_step();
      @(negedge clk);
      bus.req0_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", int'(bus.req0_ready), 0);
      chk("midrst_valid", int'(bus.rsp_valid), 0);
      model_step();
      @(negedge clk);
      bus.req0_valid = 1'b0;
      #1 model_step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 model_step();
      end
      run_vec(mkv(1, 0, 4, 6, 0, 0, 0, 24));

      // Error counter saturation.
      do_reset();
      for (int t = 0; t < ERRMAX + 2; t++) begin
         @(negedge clk);
         bus.req0_valid = 1'b1;
         bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom);
         bus.fault_inj = 1'b1; bus.rsp_ready = 1'b1;
         #1 model_step();
         for (int i = 0; i < 12 && m_pend; i++) begin
            @(negedge clk);
            bus.req0_valid = 1'b0;
            #1 model_step();
         end
      end
      @(negedge clk);
      bus.fault_inj = 1'b0;
      #1;
      chk("errcnt_sat", int'(bus.err_cnt), ERRMAX);
      model_step();

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 500; i++) rand_cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #400000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/mult4u_arb_ctrl.md
MULT4U_ARB_CTRL -- requirements
Module: mult4u_arb_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 2, giving the number of re-executions allowed after a redundancy mismatch (range 1..3).
REQ-002 SHALL have parameter ERRCNT_W, default 8, giving the width of the saturating error counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 bit each: requester has an operand pair pending.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 bit each: requester's operands are accepted this cycle.
REQ-007 SHALL have ports req0_a/req0_b/req1_a/req1_b, input, 4 bits each: unsigned operands.
REQ-008 SHALL have port fault_inj, input, 1 bit: test hook that inverts bit 0 of the pass-2 product while high.
REQ-009 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-010 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-011 SHALL have port rsp_id, output, 1 bit: index of the requester being answered.
REQ-012 SHALL have port rsp_prod, output, 8 bits: unsigned product A*B.
REQ-013 SHALL have port rsp_err, output, 1 bit: redundancy check failed after all retries.
REQ-014 SHALL have port err_cnt, output, ERRCNT_W bits: count of responses delivered with rsp_err=1.

Function
REQ-015 SHALL use a four-state FSM (IDLE, PASS1, PASS2, RESP) to sequence one shared 4x4 combinational multiplier.
REQ-016 In IDLE, SHALL assert exactly one reqN_ready, combinationally, for the granted requester: round-robin, favouring the requester not granted most recently; when only one requester is valid, that requester is granted.
REQ-017 On the valid&ready handshake, SHALL latch both operands and the requester id, and go to PASS1; reqN_ready SHALL be 0 in all other states.
REQ-018 In PASS1, SHALL register P1 = A*B and go to PASS2.
REQ-019 In PASS2, SHALL compute P2 = B*A (operands swapped), XOR its bit 0 with fault_inj, and compare P2 with P1.
REQ-020 On a match in PASS2, SHALL go to RESP with rsp_prod=P1 and rsp_err=0.
REQ-021 On a mismatch, SHALL follow REQ-031/REQ-032.
REQ-022 In RESP, SHALL hold rsp_valid=1 with rsp_id/rsp_prod/rsp_err stable until rsp_ready=1, then go to IDLE.
REQ-023 A new request SHALL NOT be accepted in the cycle the response handshake completes.
REQ-024 With no retry and rsp_ready held high, the latency from the accept edge to the rsp_valid rise SHALL be exactly 2 cycles, and the throughput SHALL be one operation per 4 cycles.
REQ-025 SHALL increment err_cnt on each response handshake with rsp_err=1, saturating at all-ones without wrap.
REQ-026 Outputs rsp_id/rsp_prod/rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-027 When rst_n is asserted, SHALL immediately force: state=IDLE; round-robin pointer favouring requester 0; retry count 0; rsp_valid, rsp_id, rsp_prod, rsp_err and err_cnt all 0.
REQ-028 Reset in any non-IDLE state SHALL abandon the operation without emitting a response.
REQ-029 reqN_ready SHALL be 0 while rst_n is low.

Configuration
REQ-030 Macro MULT4U_ARB_RETRY_EN SHALL control the retry feature.
REQ-031 With MULT4U_ARB_RETRY_EN defined, a mismatch while retry count < MAX_RETRY SHALL increment the retry count and return to PASS1; a mismatch at MAX_RETRY SHALL go to RESP with rsp_err=1 and rsp_prod=P1.
REQ-032 With MULT4U_ARB_RETRY_EN undefined, any mismatch SHALL go directly to RESP with rsp_err=1, and the retry counter SHALL not exist.
REQ-033 The retry count SHALL clear on each accept.

Structure
REQ-034 Package mult4u_pkg SHALL hold the FSM state enum, operand width 4, product width 8 and the default MAX_RETRY.
REQ-035 The multiplier SHALL be a single sub-module, mult4u_core (purely combinational, 4x4 -> 8 unsigned), instantiated once and shared by both passes.

Verification
REQ-036 req0 A=15, B=15, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_prod=225, rsp_id=0, rsp_err=0.
REQ-037 req0 (3,5) and req1 (7,9) valid in the same cycle from reset -> req0 served first (15), then req1 (63); with both kept valid, grants alternate 0,1,0,1.
REQ-038 rsp_ready=0 for 5 cycles after rsp_valid rises -> response held stable, no req*_ready, IDLE entered only after rsp_ready=1.
REQ-039 fault_inj=1 continuously, RETRY_EN on, MAX_RETRY=2 -> 3 PASS2 mismatches, then rsp_err=1, rsp_prod=A*B, err_cnt increments by 1; with RETRY_EN off -> rsp_err=1 after the first PASS2.
REQ-040 fault_inj pulsed only during the first PASS2, RETRY_EN on -> one retry, then rsp_err=0 with the correct product.
REQ-041 rst_n pulsed low during PASS2 -> no response emitted, all outputs 0, the next request is served normally.
